// File: rtl/chacha_pkg.sv
// Shared ChaCha constants: word/state widths, rotations, quad index tables, FSM encodings.
// Used by chacha_inv_qr and chacha_inv_rounds.
package chacha_pkg;

    localparam int WORD_W  = 32;
    localparam int STATE_W = 512;
    localparam int NWORDS  = 16;

    localparam int ROT16 = 16;
    localparam int ROT12 = 12;
    localparam int ROT8  = 8;
    localparam int ROT7  = 7;

    // Four quads of four word indices, quad 0 in the top nibbles.
    localparam logic [63:0] COL_TBL  = 64'h048C_159D_26AE_37BF;
    localparam logic [63:0] DIAG_TBL = 64'h05AF_16BC_278D_349E;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ROUNDS = 2'b01,
        ST_DONE   = 2'b10
    } inv_state_e;

    function automatic logic [3:0] tbl_idx(input logic [63:0] tbl, input int q, input int k);
        logic [5:0] pos;
        pos = 6'(60 - 4 * (4 * q + k));
        return tbl[pos +: 4];
    endfunction

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/chacha_inv_qr.sv
// Combinational inverse ChaCha quarter round: undoes the forward QR steps in reverse order,
// each step consuming the values produced by the previous one.
module chacha_inv_qr
    import chacha_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] c,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] a_prim,
    output logic [WORD_W-1:0] b_prim,
    output logic [WORD_W-1:0] c_prim,
    output logic [WORD_W-1:0] d_prim
);

    logic [WORD_W-1:0] a1_s, b1_s, c1_s, d1_s;

    // Undo the second half of the forward QR (rotations 7 and 8).
    assign b1_s = rotr(b, ROT7) ^ c;
    assign c1_s = c - d;
    assign d1_s = rotr(d, ROT8) ^ a;
    assign a1_s = a - b1_s;

    // Undo the first half of the forward QR (rotations 12 and 16).
    assign b_prim = rotr(b1_s, ROT12) ^ c1_s;
    assign c_prim = c1_s - d1_s;
    assign d_prim = rotr(d1_s, ROT16) ^ a1_s;
    assign a_prim = a1_s - b_prim;

endmodule

// File: rtl/chacha_inv_rounds.sv
// Iterative inverse of the ChaCha rounds: one inverse round per cycle, diagonal first.
// Optional CHACHA_INV_SELFCHECK_EN adds an expected-state input and a registered match flag.
module chacha_inv_rounds
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in,
`ifdef CHACHA_INV_SELFCHECK_EN
    input  logic [STATE_W-1:0] expected,
    output logic               match,
`endif
    output logic               ready,
    output logic               valid,
    output logic [STATE_W-1:0] state_out
);

    localparam int CTR_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    inv_state_e         state_r, state_n;
    logic [CTR_W-1:0]   round_ctr_r;
    logic [STATE_W-1:0] work_r;
    logic [STATE_W-1:0] next_work_s;
    logic               ready_r, valid_r;
    logic               load_s, step_s, last_s, col_s;

    logic [WORD_W-1:0] w_s  [NWORDS];
    logic [WORD_W-1:0] nw_s [NWORDS];
    logic [WORD_W-1:0] qa_s [4];
    logic [WORD_W-1:0] qb_s [4];
    logic [WORD_W-1:0] qc_s [4];
    logic [WORD_W-1:0] qd_s [4];
    logic [WORD_W-1:0] pa_s [4];
    logic [WORD_W-1:0] pb_s [4];
    logic [WORD_W-1:0] pc_s [4];
    logic [WORD_W-1:0] pd_s [4];

    // Odd rounds (counted from the last forward round) are column rounds.
    assign col_s  = round_ctr_r[0];
    assign last_s = (round_ctr_r == CTR_W'(ROUNDS - 1));

    for (genvar i = 0; i < NWORDS; i++) begin : g_words
        assign w_s[i] = work_r[STATE_W-1-WORD_W*i -: WORD_W];
        assign next_work_s[STATE_W-1-WORD_W*i -: WORD_W] = nw_s[i];
    end

    for (genvar q = 0; q < 4; q++) begin : g_qr
        assign qa_s[q] = col_s ? w_s[tbl_idx(COL_TBL, q, 0)] : w_s[tbl_idx(DIAG_TBL, q, 0)];
        assign qb_s[q] = col_s ? w_s[tbl_idx(COL_TBL, q, 1)] : w_s[tbl_idx(DIAG_TBL, q, 1)];
        assign qc_s[q] = col_s ? w_s[tbl_idx(COL_TBL, q, 2)] : w_s[tbl_idx(DIAG_TBL, q, 2)];
        assign qd_s[q] = col_s ? w_s[tbl_idx(COL_TBL, q, 3)] : w_s[tbl_idx(DIAG_TBL, q, 3)];

        chacha_inv_qr u_inv_qr (
            .a      (qa_s[q]),
            .b      (qb_s[q]),
            .c      (qc_s[q]),
            .d      (qd_s[q]),
            .a_prim (pa_s[q]),
            .b_prim (pb_s[q]),
            .c_prim (pc_s[q]),
            .d_prim (pd_s[q])
        );
    end

    // Scatter the quarter-round results back to their word positions.
    always_comb begin
        for (int i = 0; i < NWORDS; i++) begin
            nw_s[i] = w_s[i];
        end
        for (int q = 0; q < 4; q++) begin
            if (col_s) begin
                nw_s[tbl_idx(COL_TBL, q, 0)] = pa_s[q];
                nw_s[tbl_idx(COL_TBL, q, 1)] = pb_s[q];
                nw_s[tbl_idx(COL_TBL, q, 2)] = pc_s[q];
                nw_s[tbl_idx(COL_TBL, q, 3)] = pd_s[q];
            end else begin
                nw_s[tbl_idx(DIAG_TBL, q, 0)] = pa_s[q];
                nw_s[tbl_idx(DIAG_TBL, q, 1)] = pb_s[q];
                nw_s[tbl_idx(DIAG_TBL, q, 2)] = pc_s[q];
                nw_s[tbl_idx(DIAG_TBL, q, 3)] = pd_s[q];
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_n = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n = ST_ROUNDS;
                    load_s  = 1'b1;
                end else begin
                    state_n = state_r;
                end
            end
            ST_ROUNDS: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_ROUNDS;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_n;
            ready_r <= (state_n != ST_ROUNDS);
            valid_r <= (state_n == ST_DONE);
        end
    end

    // Working register and round counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_r      <= {STATE_W{1'b0}};
            round_ctr_r <= {CTR_W{1'b0}};
        end else if (load_s) begin
            work_r      <= state_in;
            round_ctr_r <= {CTR_W{1'b0}};
        end else if (step_s) begin
            work_r      <= next_work_s;
            round_ctr_r <= round_ctr_r + CTR_W'(1);
        end else begin
            work_r      <= work_r;
            round_ctr_r <= round_ctr_r;
        end
    end

    assign ready     = ready_r;
    assign valid     = valid_r;
    assign state_out = work_r;

`ifdef CHACHA_INV_SELFCHECK_EN
    logic [STATE_W-1:0] expected_r;
    logic               match_r;

    // Compare the recovered state on the final round; cleared by the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expected_r <= {STATE_W{1'b0}};
            match_r    <= 1'b0;
        end else if (load_s) begin
            expected_r <= expected;
            match_r    <= 1'b0;
        end else if (step_s && last_s) begin
            expected_r <= expected_r;
            match_r    <= (next_work_s == expected_r);
        end else begin
            expected_r <= expected_r;
            match_r    <= match_r;
        end
    end

    assign match = match_r;
`endif

endmodule

// File: tb/tb_chacha_inv_rounds.sv
// Directed bench for chacha_inv_rounds (ROUNDS=20) and chacha_inv_qr; exercises the
// CHACHA_INV_SELFCHECK_EN ports when that macro is defined.
module tb_chacha_inv_rounds;

    localparam logic [511:0] RFC_OUT = 512'h837778ab_e238d763_a67ae21e_5950bb2f_c4f2d0c7_fc62bb2f_8fa018fc_3f5ec7b7_335271c2_f29489f3_eabda8fc_82e46ebd_d19c12b4_b04e16de_9e83d0cb_4e3c50a2;
    localparam logic [511:0] RFC_IN  = 512'h61707865_3320646e_79622d32_6b206574_03020100_07060504_0b0a0908_0f0e0d0c_13121110_17161514_1b1a1918_1f1e1d1c_00000001_09000000_4a000000_00000000;

    logic         clk;
    logic         reset;
    logic         start;
    logic [511:0] state_in;
    logic         ready;
    logic         valid;
    logic [511:0] state_out;
    logic [511:0] expected;
    logic         match;
    logic [31:0]  qa, qb, qc, qd, ra, rb, rc, rd;

    int checks;
    int errors;
    int lat;

    typedef struct {
        logic [127:0] in_v;
        logic [127:0] exp_v;
    } qr_vec_t;

    qr_vec_t qr_tbl [4];

    chacha_inv_rounds #(.ROUNDS(20)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .state_in  (state_in),
`ifdef CHACHA_INV_SELFCHECK_EN
        .expected  (expected),
        .match     (match),
`endif
        .ready     (ready),
        .valid     (valid),
        .state_out (state_out)
    );

`ifndef CHACHA_INV_SELFCHECK_EN
    assign match = 1'b0;
`endif

    chacha_inv_qr u_qr (
        .a (qa), .b (qb), .c (qc), .d (qd),
        .a_prim (ra), .b_prim (rb), .c_prim (rc), .d_prim (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Forward reference quarter round.
    function automatic logic [127:0] fqr(input logic [31:0] a_i, b_i, c_i, d_i);
        logic [31:0] a, b, c, d;
        a = a_i; b = b_i; c = c_i; d = d_i;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    // Forward 20-round core without the feed-forward addition.
    function automatic logic [511:0] fwd20(input logic [511:0] s);
        logic [31:0]  x [16];
        int           q4 [32];
        logic [127:0] r;
        logic [511:0] o;
        q4 = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15,
               0, 5, 10, 15, 1, 6, 11, 12, 2, 7, 8, 13, 3, 4, 9, 14};
        for (int i = 0; i < 16; i++) x[i] = s[511-32*i -: 32];
        for (int dr = 0; dr < 10; dr++) begin
            for (int g = 0; g < 8; g++) begin
                r = fqr(x[q4[4*g]], x[q4[4*g+1]], x[q4[4*g+2]], x[q4[4*g+3]]);
                x[q4[4*g]]   = r[127:96];
                x[q4[4*g+1]] = r[95:64];
                x[q4[4*g+2]] = r[63:32];
                x[q4[4*g+3]] = r[31:0];
            end
        end
        for (int i = 0; i < 16; i++) o[511-32*i -: 32] = x[i];
        return o;
    endfunction

    // Present a block at one sampling edge, then scramble state_in afterwards.
    task automatic launch(input logic [511:0] si, input logic [511:0] ex);
        @(negedge clk);
        state_in = si;
        expected = ex;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        state_in = ~si;
        expected = ~ex;
    endtask

    // Count edges after the start edge until valid; optionally pulse start while busy.
    task automatic run_wait(input int busy_at, output int cnt);
        cnt = 0;
        while (valid !== 1'b1 && cnt < 100) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            start = (cnt == busy_at);
            if (cnt == busy_at) state_in = '0;
        end
        start = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        state_in = '0;
        expected = '0;
        qr_tbl[0] = '{in_v: 128'hea2a92f4_cb1cf8ce_4581472e_5881c4bb, exp_v: 128'h11111111_01020304_9b8d6f43_01234567};
        qr_tbl[1] = '{in_v: 128'h0,                                   exp_v: 128'h0};
        qr_tbl[2] = '{in_v: 128'h00000000_00000000_00000000_00000001, exp_v: 128'h00000001_ffffffff_feffffff_00000100};
        qr_tbl[3] = '{in_v: 128'h00000000_00000001_00000000_00000000, exp_v: 128'hfdffe000_00002000_00000000_fe000000};

        for (int i = 0; i < 4; i++) begin
            {qa, qb, qc, qd} = qr_tbl[i].in_v;
            #1;
            chk($sformatf("inv_qr_vec%0d", i), {384'h0, ra, rb, rc, rd}, {384'h0, qr_tbl[i].exp_v});
        end

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", ready, 1);
        chk("reset_valid", valid, 0);
        chk("reset_state_out", state_out, '0);
        chk("reset_match", match, 0);

        // Full block.
        launch(RFC_OUT, RFC_IN);
        chk("busy_ready", ready, 0);
        chk("busy_valid", valid, 0);
        run_wait(0, lat);
        chk("full_latency", lat, 20);
        chk("full_state_out", state_out, RFC_IN);
        chk("full_ready", ready, 1);
`ifdef CHACHA_INV_SELFCHECK_EN
        chk("match_good", match, 1);
`endif

        // Start pulsed while busy is ignored.
        launch(RFC_OUT, RFC_IN ^ 512'h1);
`ifdef CHACHA_INV_SELFCHECK_EN
        chk("match_cleared_on_start", match, 0);
`endif
        run_wait(5, lat);
        chk("busy_latency", lat, 20);
        chk("busy_state_out", state_out, RFC_IN);
`ifdef CHACHA_INV_SELFCHECK_EN
        chk("match_bad_expected", match, 0);
`endif

        // Back-to-back from DONE with all-zero input.
        launch('0, '0);
        chk("b2b_valid_drop", valid, 0);
        chk("b2b_new_load", state_out, '0);
        run_wait(0, lat);
        chk("b2b_latency", lat, 20);
        chk("b2b_roundtrip", fwd20(state_out), '0);

        // Asynchronous reset mid-run.
        launch(RFC_OUT, RFC_IN);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ready", ready, 1);
        chk("midrst_valid", valid, 0);
        chk("midrst_state_out", state_out, '0);
        @(negedge clk);
        reset = 1'b0;
        launch(RFC_OUT, RFC_IN);
        run_wait(0, lat);
        chk("post_rst_latency", lat, 20);
        chk("post_rst_state_out", state_out, RFC_IN);
`ifdef CHACHA_INV_SELFCHECK_EN
        chk("post_rst_match", match, 1);
        launch(RFC_OUT, RFC_IN);
        chk("match_cleared_again", match, 0);
        run_wait(0, lat);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
